vga_timing_gen: RTL and testbench

- Generates 640x480@60 VGA raster timing for the display path.
- Produces the DrawX/DrawY pixel coordinates consumed by color_mapper, plus VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N and VGA_CLK for the DAC.
- Derives the 25 MHz pixel rate from the 50 MHz system clock.
- Delays sync and blank by a configurable number of pixel ticks so they stay aligned with colour-path pipelining.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/sync_delay_line.sv | 50 +++++
 rtl/vga_timing_gen.sv | 162 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants and sync bundle type
//
// Purpose: default 640x480@60 timing numbers, the {hs, vs, blank_n} bundle
// carried through the sync delay line, and its idle (reset) value.
// Ports: none (package).
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int CLK_DIV_DEF   = 2;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_sync_t;

    // Both syncs inactive (high), picture blanked.
    localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - pixel-tick shift register for the sync/blank bundle
//
// Purpose: delays the sync bundle by DEPTH pixel ticks so it lines up with a
// pipelined colour path. DEPTH = 0 is a straight wire.
// Ports:
//   Clk   - system clock
//   Reset - synchronous, active-high; all stages load RESET_VAL
//   en    - shift enable (pixel tick)
//   d     - bundle in
//   q     - bundle out, DEPTH ticks later
module sync_delay_line
    import vga_timing_pkg::*;
#(
    parameter int     DEPTH     = 0,
    parameter type    T_SYNC    = vga_sync_t,
    parameter T_SYNC  RESET_VAL = SYNC_IDLE
) (
    input  logic  Clk,
    input  logic  Reset,
    input  logic  en,
    input  T_SYNC d,
    output T_SYNC q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused_bypass;
            assign w_unused_bypass = ^{Clk, Reset, en};
            assign q = d;
        end else begin : g_shift
            T_SYNC r_stage [DEPTH];

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RESET_VAL;
                    end
                end else if (en) begin
                    r_stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (pixel counters, syncs, pulses)
//
// Purpose: divides Clk down to a pixel tick, runs the horizontal/vertical
// counters, decodes sync/blank and delays them by SYNC_DELAY ticks.
// Ports:
//   Clk, Reset   - system clock, synchronous active-high reset
//   pix_ce       - one-Clk pixel-tick enable
//   VGA_CLK      - pixel clock to the DAC
//   VGA_HS/VS    - active-low syncs
//   VGA_BLANK_N  - high in the visible region
//   VGA_SYNC_N   - tied low
//   DrawX/DrawY  - current column / row
//   frame_start  - one-Clk pulse on the first cycle of (0,0)
//   line_start   - one-Clk pulse on the first cycle of column 0
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int SYNC_DELAY = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pix_ce,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       line_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic [2:0] DIV_HALF = 3'(CLK_DIV / 2);

    // ---------------------------------------------------------------------
    // Clock divider. pix_ce and VGA_CLK are decoded from the next divider
    // value so the registered versions line up with div_cnt itself.
    // ---------------------------------------------------------------------
    logic [2:0] r_div_cnt;
    logic [2:0] w_div_next;
    logic       r_pix_ce;
    logic       r_vga_clk;

    assign w_div_next = (r_div_cnt == DIV_LAST) ? 3'd0 : r_div_cnt + 3'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_div_cnt <= 3'd0;
            r_pix_ce  <= 1'b0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_pix_ce  <= (w_div_next == DIV_LAST);
            r_vga_clk <= (w_div_next >= DIV_HALF);
        end
    end

    // ---------------------------------------------------------------------
    // Raster counters and raw sync decode
    // ---------------------------------------------------------------------
    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic [9:0] w_hc_next;
    logic [9:0] w_vc_next;
    logic       w_h_wrap;
    logic       w_v_wrap;
    vga_sync_t  w_raw_next;
    vga_sync_t  r_raw;
    vga_sync_t  w_delayed;
    logic       r_line_start;
    logic       r_frame_start;

    assign w_h_wrap = (r_hc == H_LAST);
    assign w_v_wrap = (r_vc == V_LAST);

    always_comb begin
        w_hc_next = r_hc;
        w_vc_next = r_vc;
        if (r_pix_ce) begin
            w_hc_next = w_h_wrap ? 10'd0 : r_hc + 10'd1;
            if (w_h_wrap) begin
                w_vc_next = w_v_wrap ? 10'd0 : r_vc + 10'd1;
            end
        end
    end

    // Decoding the next-state counters lets the registered syncs change on
    // the same edge as DrawX/DrawY.
    always_comb begin
        w_raw_next         = SYNC_IDLE;
        w_raw_next.hs      = !((w_hc_next >= H_SYNC_START) && (w_hc_next < H_SYNC_END));
        w_raw_next.vs      = !((w_vc_next >= V_SYNC_START) && (w_vc_next < V_SYNC_END));
        w_raw_next.blank_n = (w_hc_next < H_VIS_END) && (w_vc_next < V_VIS_END);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hc          <= 10'd0;
            r_vc          <= 10'd0;
            r_raw         <= SYNC_IDLE;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hc          <= w_hc_next;
            r_vc          <= w_vc_next;
            r_line_start  <= r_pix_ce && w_h_wrap;
            r_frame_start <= r_pix_ce && w_h_wrap && w_v_wrap;
            // Only on pixel ticks: the pixel shown right after reset keeps
            // the idle (blanked) bundle for its whole duration.
            if (r_pix_ce) begin
                r_raw <= w_raw_next;
            end
        end
    end

    sync_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .T_SYNC    (vga_sync_t),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (r_pix_ce),
        .d     (r_raw),
        .q     (w_delayed)
    );

    assign pix_ce      = r_pix_ce;
    assign VGA_CLK     = r_vga_clk;
    assign VGA_HS      = w_delayed.hs;
    assign VGA_VS      = w_delayed.vs;
    assign VGA_BLANK_N = w_delayed.blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (two configurations)
module tb_vga_timing_gen;

    localparam int HV = 16, HF = 4, HSW = 6, HB = 4;
    localparam int VV = 6,  VF = 2, VSW = 2, VB = 3;
    localparam int HT = HV + HF + HSW + HB;
    localparam int VT = VV + VF + VSW + VB;
    localparam int DIV_A = 2, DLY_A = 0;
    localparam int DIV_B = 4, DLY_B = 2;

    typedef struct packed {
        logic       pix_ce;
        logic       vga_clk;
        logic       hs;
        logic       vs;
        logic       blank_n;
        logic       sync_n;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       ls;
    } obs_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic       a_ce, a_clk, a_hs, a_vs, a_bn, a_sn, a_fs, a_ls;
    logic [9:0] a_x, a_y;
    logic       b_ce, b_clk, b_hs, b_vs, b_bn, b_sn, b_fs, b_ls;
    logic [9:0] b_x, b_y;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .CLK_DIV(DIV_A), .SYNC_DELAY(DLY_A)
    ) u_a (
        .Clk(Clk), .Reset(Reset), .pix_ce(a_ce), .VGA_CLK(a_clk),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn),
        .DrawX(a_x), .DrawY(a_y), .frame_start(a_fs), .line_start(a_ls)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .CLK_DIV(DIV_B), .SYNC_DELAY(DLY_B)
    ) u_b (
        .Clk(Clk), .Reset(Reset), .pix_ce(b_ce), .VGA_CLK(b_clk),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn),
        .DrawX(b_x), .DrawY(b_y), .frame_start(b_fs), .line_start(b_ls)
    );

    obs_t a_act, b_act;
    assign a_act = {a_ce, a_clk, a_hs, a_vs, a_bn, a_sn, a_x, a_y, a_fs, a_ls};
    assign b_act = {b_ce, b_clk, b_hs, b_vs, b_bn, b_sn, b_x, b_y, b_fs, b_ls};

    int   tests = 0;
    int   fails = 0;
    int   k = 0;
    bit   valid = 0;
    int   cyc = 0;
    obs_t qa[$];
    obs_t qb[$];

    // Expected outputs k Clk cycles after the last reset edge, from the raster
    // rules: pixel n = k / div, sync bundle shows pixel n - dly, and the pixel
    // displayed right after reset is blanked.
    function automatic obs_t model(input int kk, input int div, input int dly);
        obs_t e;
        int   n, ph, m, hm, vm;
        n  = kk / div;
        ph = kk % div;
        m  = n - dly;
        e.pix_ce  = (ph == div - 1);
        e.vga_clk = (ph >= div / 2);
        e.sync_n  = 1'b0;
        e.x       = 10'(n % HT);
        e.y       = 10'((n / HT) % VT);
        e.ls      = (n > 0) && (n % HT == 0) && (ph == 0);
        e.fs      = (n > 0) && (n % (HT * VT) == 0) && (ph == 0);
        if (m <= 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.blank_n = 1'b0;
        end else begin
            hm = m % HT;
            vm = (m / HT) % VT;
            e.hs      = !(hm >= HV + HF && hm < HV + HF + HSW);
            e.vs      = !(vm >= VV + VF && vm < VV + VF + VSW);
            e.blank_n = (hm < HV) && (vm < VV);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s t=%0t k=%0d: got %0d expected %0d", nm, $time, k, act, exp);
        end
    endtask

    task automatic cmp(input string inst, input obs_t e, input obs_t a);
        chk({inst, ".pix_ce"},      32'(a.pix_ce),  32'(e.pix_ce));
        chk({inst, ".VGA_CLK"},     32'(a.vga_clk), 32'(e.vga_clk));
        chk({inst, ".VGA_HS"},      32'(a.hs),      32'(e.hs));
        chk({inst, ".VGA_VS"},      32'(a.vs),      32'(e.vs));
        chk({inst, ".VGA_BLANK_N"}, 32'(a.blank_n), 32'(e.blank_n));
        chk({inst, ".VGA_SYNC_N"},  32'(a.sync_n),  32'(e.sync_n));
        chk({inst, ".DrawX"},       32'(a.x),       32'(e.x));
        chk({inst, ".DrawY"},       32'(a.y),       32'(e.y));
        chk({inst, ".frame_start"}, 32'(a.fs),      32'(e.fs));
        chk({inst, ".line_start"},  32'(a.ls),      32'(e.ls));
    endtask

    // One Clk edge with Reset = r; afterwards queue what both DUTs must show.
    task automatic tick(input bit r);
        Reset = r;
        @(posedge Clk);
        #1;
        if (r) begin
            k = 0;
            valid = 1;
        end else if (valid) begin
            k = k + 1;
        end
        if (valid) begin
            qa.push_back(model(k, DIV_A, DLY_A));
            qb.push_back(model(k, DIV_B, DLY_B));
        end
    endtask

    // Monitor: scoreboard pops plus independent interval measurements.
    int last_fs_a = -1, last_fs_b = -1;
    int hs_cnt = 0;
    bit hs_ok = 0;

    always @(negedge Clk) begin
        obs_t ea, eb;
        cyc++;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            cmp("a", ea, a_act);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            cmp("b", eb, b_act);
        end
        if (valid) begin
            if (a_fs === 1'b1) begin
                if (last_fs_a >= 0) chk("a.frame_period", 32'(cyc - last_fs_a), 32'(HT * VT * DIV_A));
                last_fs_a = cyc;
            end
            if (b_fs === 1'b1) begin
                if (last_fs_b >= 0) chk("b.frame_period", 32'(cyc - last_fs_b), 32'(HT * VT * DIV_B));
                last_fs_b = cyc;
            end
            if (a_hs === 1'b0) begin
                hs_cnt++;
            end else begin
                if (hs_cnt > 0 && hs_ok) chk("a.hsync_width", 32'(hs_cnt), 32'(HSW * DIV_A));
                hs_cnt = 0;
                hs_ok  = 1;
            end
            if (Reset) begin
                last_fs_a = -1;
                last_fs_b = -1;
                hs_cnt    = 0;
                hs_ok     = 0;
            end
        end
    end

    initial begin
        int found;
        repeat (3) tick(1'b1);
        // Reset-free run over more than two frames of the slower instance.
        repeat (4000) tick(1'b0);

        // Single-cycle reset while instance a is inside horizontal sync.
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            if ((k / DIV_A) % HT == HV + HF + 2) found = 1;
            else tick(1'b0);
        end
        chk("find_hsync_point", 32'(found), 32'd1);
        tick(1'b1);
        repeat (2000) tick(1'b0);

        // Randomly placed resets of 1..3 cycles.
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 899) == 0) begin
                repeat ($urandom_range(1, 3)) tick(1'b1);
            end else begin
                tick(1'b0);
            end
        end

        repeat (2) @(negedge Clk);
        #1;
        chk("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
        chk("enough_compares", 32'(tests > 100000), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
